cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  8-phase control sequencer for the RISC CPU; initiator side of the memory-address path.
//  Drives the address-mux select (1=PC/instruction, 0=operand), memory rd/wr, register loads, PC control.
//  Sits between the instruction register (opcode) / ALU (zero flag) and the datapath (mux, PC, IR, AC, memory).
//  One instruction per 8 clocks; HLT freezes the machine until reset.
// PARAMETERS
//  OPC_W   3   opcode width; instruction = {opcode[OPC_W-1:0], addr[4:0]}
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  opcode   in   OPC_W  current IR opcode, sampled combinationally per phase
//  zero     in   1      accumulator==0 flag from ALU
//  sel      out  1      address-mux select: 1=inst_addr (PC), 0=op_addr (IR[4:0])
//  rd       out  1      memory read enable
//  wr       out  1      memory write strobe
//  ld_ir    out  1      load instruction register
//  ld_ac    out  1      load accumulator
//  ld_pc    out  1      load PC from IR address (jump)
//  inc_pc   out  1      increment PC
//  data_e   out  1      drive AC onto memory data bus
//  halt     out  1      sticky halt indicator
//  phase    out  3      current phase (debug/observability)
// BEHAVIOUR
//  Opcodes: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7; ALUOP = ADD|AND|XOR|LDA.
//  Reset (async, rst_n=0): phase=INST_ADDR(0), halted flag=0; outputs decode from phase 0 -> sel=1, all others 0.
//  Phase register advances 0->1->...->7->0 each clk; wraps 7->0 unconditionally unless halted.
//  Outputs are combinational decode of {phase, opcode, zero, halted}; no extra latency.
//   0 INST_ADDR : sel=1
//   1 INST_FETCH: sel=1 rd=1
//   2 INST_LOAD : sel=1 rd=1 ld_ir=1
//   3 IDLE      : sel=1 rd=1 ld_ir=1
//   4 OP_ADDR   : sel=0 inc_pc=1 (if opcode!=HLT); opcode==HLT -> halt=1, inc_pc=0
//   5 OP_FETCH  : sel=0 rd=ALUOP
//   6 ALU_OP    : sel=0 rd=ALUOP inc_pc=(SKZ&&zero) ld_pc=JMP data_e=STO
//   7 STORE     : sel=0 rd=ALUOP ld_ac=ALUOP ld_pc=JMP wr=STO data_e=STO
//  Halt: at phase 4 with opcode==HLT, halted flag sets on that clk edge; phase stays 4 forever;
//   while halted: halt=1, sel=0, all strobes 0 (no inc_pc repeat). Only rst_n clears it.
//  wr is asserted only in phase 7 and only with data_e=1 in phases 6 and 7 (bus driven one cycle ahead).
//  ld_pc and inc_pc never both 1 in the same cycle (JMP and SKZ are exclusive).
//  Opcode/zero changes mid-phase take effect combinationally; datapath guarantees IR stable from phase 4.
//  X on opcode outside phases 4-7 must not propagate to outputs (phases 0-3 ignore opcode).
//  Reset asserted mid-instruction: outputs return to phase-0 values immediately (async), no wr glitch past deassert.
// STRUCTURE
//  Shared package risc_pkg: opcode localparams (OP_HLT..OP_JMP), phase localparams (PH_INST_ADDR..PH_STORE),
//   OPC_W default; same package used by ALU and IR decode.
//  Single module; phase counter + halted flag in one always block (async rst_n), decode in a second
//   combinational block. No sub-module.
// TESTING
//  1 Reset: rst_n=0 mid-phase 5 -> phase=0, sel=1, rd/wr/ld_*/inc_pc/data_e/halt=0 without clk edge.
//  2 LDA (opcode=5): phases 0..7 -> sel=1,1,1,1,0,0,0,0; rd=0,1,1,1,0,1,1,1; ld_ir on 2,3; inc_pc on 4; ld_ac on 7.
//  3 STO (opcode=6): data_e=1 in phases 6,7; wr=1 only phase 7; rd=0 in 5-7; ld_ac never.
//  4 SKZ (opcode=1): zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc only in phase 4.
//  5 JMP (opcode=7): ld_pc=1 in phases 6,7; inc_pc=1 only phase 4; wr=0 throughout.
//  6 HLT (opcode=0): at phase 4 halt=1; after 20 further clks phase=4, halt=1, all strobes 0; rst_n pulse -> phase=0, halt=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RISC CPU definitions: opcode and sequencer phase encodings used by the
// control sequencer, ALU and instruction decode.
package risc_pkg;

  localparam int OPC_W_DEF = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Instructions that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// 8-phase control sequencer for the RISC CPU: one instruction per 8 clocks,
// outputs are a pure combinational decode of {phase, opcode, zero, halted}.
module cpu_sequencer
  import risc_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase
);

  logic [2:0] phase_q;
  logic       halted_q;
  logic [2:0] op;
  logic       alu_op;

  assign op     = 3'(opcode);
  assign alu_op = is_aluop(op);
  assign phase  = phase_q;

  // HLT freezes the counter on phase 4; only rst_n releases it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && op == OP_HLT) begin
        halted_q <= 1'b1;
      end else begin
        phase_q <= phase_q + 3'd1;
      end
    end
  end

  // Phases 0-3 never look at opcode, so an unsettled IR cannot reach the outputs.
  // NOTE: every output gets a default first so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          if (op == OP_HLT) begin
            halt = 1'b1;
          end else begin
            inc_pc = 1'b1;
          end
        end
        PH_OP_FETCH: begin
          rd = alu_op;
        end
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = (op == OP_SKZ) && zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase vector table for each opcode,
// then hand-written halt and asynchronous-reset sequences.
module tb_cpu_sequencer;
  import risc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;

  cpu_sequencer #(.OPC_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
  typedef struct {
    string      name;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] exp_phase;
    logic [8:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  function automatic logic [8:0] outs();
    return {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got phase/outs %b, expected %b", name, act, exp);
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic z,
                     input logic [2:0] ph, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.opcode = op; v.zero = z; v.exp_phase = ph; v.exp_out = exp;
    vecs.push_back(v);
  endtask

  // Phases 0-3 are opcode-independent; STO drives X there to prove it.
  task automatic add_fetch(input string name, input logic [2:0] op, input logic z);
    add({name, "_p0"}, op, z, 3'd0, 9'b100_000_000);
    add({name, "_p1"}, op, z, 3'd1, 9'b110_000_000);
    add({name, "_p2"}, op, z, 3'd2, 9'b110_100_000);
    add({name, "_p3"}, op, z, 3'd3, 9'b110_100_000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    opcode = OP_HLT;
    zero   = 1'b0;

    add_fetch("lda", OP_LDA, 1'b0);
    add("lda_p4", OP_LDA, 1'b0, 3'd4, 9'b000_000_100);
    add("lda_p5", OP_LDA, 1'b0, 3'd5, 9'b010_000_000);
    add("lda_p6", OP_LDA, 1'b0, 3'd6, 9'b010_000_000);
    add("lda_p7", OP_LDA, 1'b0, 3'd7, 9'b010_010_000);

    add_fetch("sto", 3'bxxx, 1'b0);
    add("sto_p4", OP_STO, 1'b0, 3'd4, 9'b000_000_100);
    add("sto_p5", OP_STO, 1'b0, 3'd5, 9'b000_000_000);
    add("sto_p6", OP_STO, 1'b0, 3'd6, 9'b000_000_010);
    add("sto_p7", OP_STO, 1'b0, 3'd7, 9'b001_000_010);

    add_fetch("skz1", OP_SKZ, 1'b1);
    add("skz1_p4", OP_SKZ, 1'b1, 3'd4, 9'b000_000_100);
    add("skz1_p5", OP_SKZ, 1'b1, 3'd5, 9'b000_000_000);
    add("skz1_p6", OP_SKZ, 1'b1, 3'd6, 9'b000_000_100);
    add("skz1_p7", OP_SKZ, 1'b1, 3'd7, 9'b000_000_000);

    add_fetch("skz0", OP_SKZ, 1'b0);
    add("skz0_p4", OP_SKZ, 1'b0, 3'd4, 9'b000_000_100);
    add("skz0_p5", OP_SKZ, 1'b0, 3'd5, 9'b000_000_000);
    add("skz0_p6", OP_SKZ, 1'b0, 3'd6, 9'b000_000_000);
    add("skz0_p7", OP_SKZ, 1'b0, 3'd7, 9'b000_000_000);

    add_fetch("jmp", OP_JMP, 1'b1);
    add("jmp_p4", OP_JMP, 1'b1, 3'd4, 9'b000_000_100);
    add("jmp_p5", OP_JMP, 1'b1, 3'd5, 9'b000_000_000);
    add("jmp_p6", OP_JMP, 1'b1, 3'd6, 9'b000_001_000);
    add("jmp_p7", OP_JMP, 1'b1, 3'd7, 9'b000_001_000);

    add_fetch("xor", OP_XOR, 1'b1);
    add("xor_p4", OP_XOR, 1'b1, 3'd4, 9'b000_000_100);
    add("xor_p5", OP_XOR, 1'b1, 3'd5, 9'b010_000_000);
    add("xor_p6", OP_XOR, 1'b1, 3'd6, 9'b010_000_000);
    add("xor_p7", OP_XOR, 1'b1, 3'd7, 9'b010_010_000);

    add_fetch("hlt", OP_HLT, 1'b0);
    add("hlt_p4", OP_HLT, 1'b0, 3'd4, 9'b000_000_001);

    // Reset state, checked before any clock edge.
    #2;
    check("reset_init", {phase, outs()}, {3'd0, 9'b100_000_000});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].opcode;
      zero   = vecs[i].zero;
      #1;
      check(vecs[i].name, {phase, outs()}, {vecs[i].exp_phase, vecs[i].exp_out});
      @(negedge clk);
    end

    // Halted: frozen at phase 4 whatever the opcode, no repeated inc_pc.
    opcode = OP_LDA;
    zero   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("halted_c%0d", c), {phase, outs()}, {3'd4, 9'b000_000_001});
      @(negedge clk);
    end

    rst_n = 1'b0;
    #1;
    check("halt_reset", {phase, outs()}, {3'd0, 9'b100_000_000});
    @(negedge clk);
    rst_n = 1'b1;

    // Restart then async reset in the middle of phase 5 of a STO.
    opcode = OP_STO;
    zero   = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_reset_p5", {phase, outs()}, {3'd5, 9'b000_000_000});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_p5", {phase, outs()}, {3'd0, 9'b100_000_000});
    @(posedge clk);
    #1;
    check("reset_held_edge", {phase, outs()}, {3'd0, 9'b100_000_000});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", {phase, outs()}, {3'd0, 9'b100_000_000});
    @(negedge clk);
    #1;
    check("after_release_p1", {phase, outs()}, {3'd1, 9'b110_000_000});

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
